// File: rtl/sub_32b_seq.sv
`default_nettype none
// ============================================================================
// Module   : sub_32b_seq
// Purpose  : Two-cycle 32-bit subtractor (A - B) built on one 16-bit adder
//            slice, low half then high half, with a start/busy/done handshake.
//            Define SUB_FLAGS_EN to build the borrow/zero/neg/ovf flag logic;
//            without it the flag ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sub_32b_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] D,
    output logic        busy,
    output logic        done,
    output logic        borrow,
    output logic        zero,
    output logic        neg,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [15:0] r_d_lo;
    logic        r_c;

    logic [15:0] w_a_half;
    logic [15:0] w_b_half;
    logic        w_cin;
    logic [16:0] w_sum;
    logic [31:0] w_d_full;

    // Shared slice: the +1 of two's-complement negation enters as the low carry-in.
    always_comb begin
        w_a_half = r_a[31:16];
        w_b_half = r_b[31:16];
        w_cin    = r_c;
        if (r_state == S_LO) begin
            w_a_half = r_a[15:0];
            w_b_half = r_b[15:0];
            w_cin    = 1'b1;
        end
    end

    assign w_sum    = {1'b0, w_a_half} + {1'b0, ~w_b_half} + {16'd0, w_cin};
    assign w_d_full = {w_sum[15:0], r_d_lo};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_d_lo  <= 16'd0;
            r_c     <= 1'b0;
            D       <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SUB_FLAGS_EN
            borrow  <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        busy    <= 1'b1;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    r_d_lo  <= w_sum[15:0];
                    r_c     <= w_sum[16];
                    r_state <= S_HI;
                end
                S_HI: begin
                    D       <= w_d_full;
                    done    <= 1'b1;
`ifdef SUB_FLAGS_EN
                    borrow  <= ~w_sum[16];
                    zero    <= (w_d_full == 32'd0);
                    neg     <= w_d_full[31];
                    ovf     <= (r_a[31] != r_b[31]) && (w_d_full[31] != r_a[31]);
`endif
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifndef SUB_FLAGS_EN
    assign borrow = 1'b0;
    assign zero   = 1'b0;
    assign neg    = 1'b0;
    assign ovf    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub_32b_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_32b_seq
// Purpose  : Directed self-checking bench for sub_32b_seq (handshake timing,
//            difference, flags, start-while-busy and mid-operation reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_32b_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] d;
    logic        busy, done, borrow, zero, neg, ovf;

    int n_checks = 0;
    int n_pass   = 0;

    sub_32b_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (a),
        .B      (b),
        .D      (d),
        .busy   (busy),
        .done   (done),
        .borrow (borrow),
        .zero   (zero),
        .neg    (neg),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] flags_now();
        return {28'd0, borrow, zero, neg, ovf};
    endfunction

    // Flags are only built with SUB_FLAGS_EN; otherwise they must read 0.
    function automatic logic [31:0] flags_exp(input logic [3:0] f);
`ifdef SUB_FLAGS_EN
        return {28'd0, f};
`else
        return 32'd0 & {28'd0, f};
`endif
    endfunction

    // Accept at edge t0, then check busy/done at every following edge.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_d, input logic [3:0] exp_f);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);               // t0
        #1 start = 1'b0; a = ~av; b = $urandom;
        @(negedge clk);
        check({tag, " busy@t0"}, {31'd0, busy}, 32'd1);
        check({tag, " done@t0"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        check({tag, " busy@t1"}, {31'd0, busy}, 32'd1);
        check({tag, " done@t1"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        check({tag, " busy@t2"}, {31'd0, busy}, 32'd1);
        check({tag, " done@t2"}, {31'd0, done}, 32'd1);
        check({tag, " D"},       d,             exp_d);
        check({tag, " flags"},   flags_now(),   flags_exp(exp_f));
        @(negedge clk);
        check({tag, " busy@t3"}, {31'd0, busy}, 32'd0);
        check({tag, " done@t3"}, {31'd0, done}, 32'd0);
        check({tag, " D hold"},  d,             exp_d);
    endtask

    initial begin
        int dones;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset D", d, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset flags", flags_now(), 32'd0);
        rst = 1'b1;

        //        tag          A             B             D             {borrow,zero,neg,ovf}
        run_op("basic",     32'd5,        32'd3,        32'h00000002, 4'b0000);
        run_op("underflow", 32'd0,        32'd1,        32'hFFFFFFFF, 4'b1010);
        run_op("carry",     32'h00010000, 32'h00000001, 32'h0000FFFF, 4'b0000);
        run_op("ovf_pos",   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001);
        run_op("zero",      32'h12345678, 32'h12345678, 32'h00000000, 4'b0100);
        run_op("ovf_neg",   32'h00000001, 32'h80000000, 32'h80000001, 4'b1011);

        // start held through LO and HI with different operands must be ignored
        @(negedge clk);
        a = 32'd9; b = 32'd1; start = 1'b1;
        @(posedge clk);
        #1 a = 32'd7; b = 32'd7;
        dones = 0;
        @(negedge clk); dones += done;      // LO
        @(negedge clk); dones += done;      // HI sampled start ignored
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); dones += done;
        end
        check("busy start count", dones, 32'd1);
        check("busy start D", d, 32'h00000008);
        check("busy start idle", {31'd0, busy}, 32'd0);

        // reset asserted at the LO->HI edge aborts the operation
        @(negedge clk);
        a = 32'd10; b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); dones += done;
        end
        check("abort done count", dones, 32'd0);
        check("abort D", d, 32'd0);
        check("abort flags", flags_now(), 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);

        run_op("after_rst", 32'd10, 32'd4, 32'h00000006, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
